// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one 16-bit word load/store at a time,
// fixed wait latency, Stall while busy, one-cycle Done/Err completion pulse.
module data_mem_responder #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemEn,
    input  logic        MemWr,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        Stall,
    output logic        Done,
    output logic        Err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("data_mem_responder: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   widx_q, widx_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic                err_q, err_d;
    logic [15:0]         dout_q, dout_d;
    logic [15:0]         mem_q [DEPTH];

    logic                illegal;
    logic                last_wait;
    logic                mem_we;

    // Misaligned, or any byte-address bit above the storage range set.
    assign illegal   = Addr[0] | (|(Addr >> (ADDR_W + 1)));
    assign last_wait = (state_q == S_WAIT) && (cnt_q == '0);
    assign mem_we    = last_wait && wr_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (MemEn) begin
                    state_d = illegal ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture, wait counter and load-data path
    always_comb begin
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        err_d   = err_q;
        dout_d  = dout_q;
        if (state_q == S_IDLE && MemEn) begin
            widx_d  = Addr[ADDR_W:1];
            wdata_d = DataIn;
            wr_d    = MemWr;
            err_d   = illegal;
            if (!illegal) begin
                cnt_d = CNT_W'(LATENCY - 1);
            end
        end else if (state_q == S_WAIT && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (last_wait && !wr_q) begin
            dout_d = mem_q[widx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            widx_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    // Storage; reset has priority so a store on the final wait edge is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[widx_q] <= wdata_q;
        end
    end

    // Output logic
    always_comb begin
        Stall = 1'b0;
        Done  = 1'b0;
        Err   = 1'b0;
        if (!rst) begin
            Stall = (state_q == S_WAIT) || (state_q == S_IDLE && MemEn);
            Done  = (state_q == S_DONE);
            Err   = (state_q == S_DONE) && err_q;
        end
    end

    assign DataOut = dout_q;

endmodule
